// File: rtl/nios2_debug_scan_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG debug scan master.
package nios2_debug_scan_pkg;

   localparam int DEF_SR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;

   // Virtual IR codes understood by the CPU debug slave
   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RSP
   } scan_state_e;

endpackage

// File: rtl/nios2_scan_tck_gen.sv
// Virtual tck generator: half-period counter plus tck register, with pulses
// flagging the clk edge on which tck will rise or fall.
module nios2_scan_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic tck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(TCK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (!en_i) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         tck_d = ~tck_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   // Pulses are asserted in the cycle before tck actually changes
   assign tck_o  = tck_q;
   assign rise_o = en_i & wrap & ~tck_q;
   assign fall_o = en_i & wrap & tck_q;

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: UIR, CDR, SDR, UDR, RTI per command.
// Optional macro NIOS2_SCAN_MASTER_RTI_HOLD_EN adds rti_hold to stretch run-test-idle.
module nios2_debug_scan_master
   import nios2_debug_scan_pkg::*;
#(
   parameter int SR_WIDTH = DEF_SR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [SR_WIDTH-1:0] cmd_data,
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
   input  logic [7:0]          rti_hold,
`endif
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [SR_WIDTH-1:0] rsp_data,
   output logic                vj_tck,
   output logic                vj_tdi,
   input  logic                vj_tdo,
   output logic [IR_WIDTH-1:0] vj_ir_in,
   output logic                vj_uir,
   output logic                vj_cdr,
   output logic                vj_sdr,
   output logic                vj_udr,
   output logic                vj_rti
);

   localparam int BIT_W = $clog2(SR_WIDTH);

   scan_state_e         state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [SR_WIDTH-1:0] tx_q, tx_d;
   logic [SR_WIDTH-1:0] rx_q, rx_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                tck_en, tck_rise, tck_fall;
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
   logic [7:0]          hold_q, hold_d;
   logic [7:0]          rti_cnt_q, rti_cnt_d;
`endif

   assign tck_en = (state_q != ST_IDLE) && (state_q != ST_RSP);

   nios2_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
      .clk    (clk),
      .reset  (reset),
      .en_i   (tck_en),
      .tck_o  (vj_tck),
      .rise_o (tck_rise),
      .fall_o (tck_fall)
   );

   // Every scan state advances on a tck falling edge, so each starts with tck low
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
      hold_d    = hold_q;
      rti_cnt_d = rti_cnt_q;
`endif
      case (state_q)
         ST_IDLE: if (cmd_valid) begin
            state_d = ST_UIR;
            ir_d    = cmd_ir;
            tx_d    = cmd_data;
            bit_d   = '0;
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
            hold_d  = rti_hold;
`endif
         end
         ST_UIR: if (tck_fall) state_d = ST_CDR;
         ST_CDR: if (tck_fall) state_d = ST_SDR;
         ST_SDR: begin
            if (tck_rise) rx_d = {vj_tdo, rx_q[SR_WIDTH-1:1]};
            if (tck_fall) begin
               tx_d = tx_q >> 1;
               if (bit_q == BIT_W'(SR_WIDTH - 1)) state_d = ST_UDR;
               else                               bit_d   = bit_q + BIT_W'(1);
            end
         end
         ST_UDR: if (tck_fall) begin
            state_d = ST_RTI;
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
            rti_cnt_d = '0;
`endif
         end
         ST_RTI: if (tck_fall) begin
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
            if (rti_cnt_q == hold_q) state_d   = ST_RSP;
            else                     rti_cnt_d = rti_cnt_q + 8'd1;
`else
            state_d = ST_RSP;
`endif
         end
         ST_RSP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
         hold_q    <= '0;
         rti_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
         hold_q    <= hold_d;
         rti_cnt_q <= rti_cnt_d;
`endif
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_data  = rx_q;
   assign vj_uir    = (state_q == ST_UIR);
   assign vj_cdr    = (state_q == ST_CDR);
   assign vj_sdr    = (state_q == ST_SDR);
   assign vj_udr    = (state_q == ST_UDR);
   assign vj_rti    = (state_q == ST_RTI);
   assign vj_tdi    = vj_sdr & tx_q[0];
   assign vj_ir_in  = tck_en ? ir_q : '0;

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Directed bench for nios2_debug_scan_master: loopback, constant tdo, backpressure,
// mid-scan reset, back-to-back at TCK_DIV=1 and (with NIOS2_SCAN_MASTER_RTI_HOLD_EN) RTI hold.
module tb_nios2_debug_scan_master;
   import nios2_debug_scan_pkg::*;

   localparam int SRW   = 38;
   localparam int LAT_A = (SRW + 4) * 2 * 2;
   localparam int LAT_B = (SRW + 4) * 2 * 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: default TCK_DIV=2
   logic            cmdValidA = 1'b0, rspReadyA = 1'b0, tdoMode = 1'b0;
   logic [1:0]      cmdIrA = '0, irExpA = '0;
   logic [SRW-1:0]  cmdDataA = '0;
   logic [7:0]      rtiHoldA = '0;
   logic            cmdReadyA, rspValidA, vjTckA, vjTdiA, vjTdoA;
   logic            vjUirA, vjCdrA, vjSdrA, vjUdrA, vjRtiA;
   logic [1:0]      vjIrA;
   logic [SRW-1:0]  rspDataA;

   assign vjTdoA = tdoMode ? 1'b1 : vjTdiA;

   nios2_debug_scan_master dutA (
      .clk(clk), .reset(reset),
      .cmd_valid(cmdValidA), .cmd_ready(cmdReadyA), .cmd_ir(cmdIrA), .cmd_data(cmdDataA),
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
      .rti_hold(rtiHoldA),
`endif
      .rsp_valid(rspValidA), .rsp_ready(rspReadyA), .rsp_data(rspDataA),
      .vj_tck(vjTckA), .vj_tdi(vjTdiA), .vj_tdo(vjTdoA), .vj_ir_in(vjIrA),
      .vj_uir(vjUirA), .vj_cdr(vjCdrA), .vj_sdr(vjSdrA), .vj_udr(vjUdrA), .vj_rti(vjRtiA)
   );

   // DUT B: TCK_DIV=1, tdo looped back
   logic            cmdValidB = 1'b0, rspReadyB = 1'b0;
   logic [SRW-1:0]  cmdDataB = '0;
   logic            cmdReadyB, rspValidB, vjTckB, vjTdiB;
   logic            vjUirB, vjCdrB, vjSdrB, vjUdrB, vjRtiB;
   logic [1:0]      vjIrB;
   logic [SRW-1:0]  rspDataB;

   nios2_debug_scan_master #(.TCK_DIV(1)) dutB (
      .clk(clk), .reset(reset),
      .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB), .cmd_ir(IR_TRACECTRL), .cmd_data(cmdDataB),
`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
      .rti_hold(8'd0),
`endif
      .rsp_valid(rspValidB), .rsp_ready(rspReadyB), .rsp_data(rspDataB),
      .vj_tck(vjTckB), .vj_tdi(vjTdiB), .vj_tdo(vjTdiB), .vj_ir_in(vjIrB),
      .vj_uir(vjUirB), .vj_cdr(vjCdrB), .vj_sdr(vjSdrB), .vj_udr(vjUdrB), .vj_rti(vjRtiB)
   );

   // Free-running activity counters on DUT A; tests compare before/after snapshots
   int sdrCyc = 0, rtiCyc = 0, uirCyc = 0, sdrRises = 0, tdiOnesSdr = 0, tdiOutside = 0, irBad = 0;
   logic prevTckA = 1'b0;
   always @(negedge clk) begin
      if (vjSdrA) begin
         sdrCyc++;
         if (vjTdiA) tdiOnesSdr++;
         if (vjTckA && !prevTckA) sdrRises++;
      end else if (vjTdiA) begin
         tdiOutside++;
      end
      if (vjRtiA) rtiCyc++;
      if (vjUirA) uirCyc++;
      if (vjUirA | vjCdrA | vjSdrA | vjUdrA | vjRtiA) begin
         if (vjIrA !== irExpA) irBad++;
      end else if (vjIrA !== 2'b00) begin
         irBad++;
      end
      prevTckA = vjTckA;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Counts posedges after an accept edge until rsp_valid is seen (bounded)
   task automatic waitRspA(output int lat, output logic [SRW-1:0] data);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!rspValidA && lat < 2000);
      data = rspDataA;
   endtask

   task automatic applyStimulus(input logic [1:0] ir, input logic [SRW-1:0] data,
                                output int lat, output logic [SRW-1:0] rdata);
      @(negedge clk);
      irExpA    = ir;
      cmdIrA    = ir;
      cmdDataA  = data;
      cmdValidA = 1'b1;
      @(posedge clk);
      #1 cmdValidA = 1'b0;
      waitRspA(lat, rdata);
   endtask

   task automatic finishRspA();
      rspReadyA = 1'b1;
      @(posedge clk);
      #1 rspReadyA = 1'b0;
      @(negedge clk);
   endtask

   int lat, s0, s1, s2, s3, s4, holdBad, rspSeen;
   logic [SRW-1:0] rdata;
   int accB[2], rspB[2], nAcc, nRsp;
   logic [SRW-1:0] dataB[2];
   logic prevUirB, prevRspB;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset cmd_ready", cmdReadyA, 1);
      checkOutput("reset rsp_valid", rspValidA, 0);
      checkOutput("reset strobes", {vjUirA, vjCdrA, vjSdrA, vjUdrA, vjRtiA, vjTckA, vjTdiA}, 0);
      checkOutput("reset ir_in", vjIrA, 0);
      checkOutput("reset rsp_data", rspDataA, 0);

      $display("[TB] loopback scan");
      s0 = sdrCyc; s1 = uirCyc; s2 = rtiCyc; s3 = sdrRises;
      applyStimulus(IR_BREAK, 38'h2A_5A5A_A5A5, lat, rdata);
      checkOutput("loop latency", lat, LAT_A);
      checkOutput("loop data", rdata, 38'h2A_5A5A_A5A5);
      checkOutput("loop uir cycles", uirCyc - s1, 4);
      checkOutput("loop sdr cycles", sdrCyc - s0, SRW * 4);
      checkOutput("loop rti cycles", rtiCyc - s2, 4);
      checkOutput("loop tck rises", sdrRises - s3, SRW);
      finishRspA();
      checkOutput("loop ready after rsp", cmdReadyA, 1);
      checkOutput("loop valid after rsp", rspValidA, 0);

      $display("[TB] constant tdo scan");
      tdoMode = 1'b1;
      s0 = sdrCyc; s1 = tdiOnesSdr; s3 = sdrRises;
      applyStimulus(IR_TRACEMEM, '0, lat, rdata);
      checkOutput("ones data", rdata, 38'h3F_FFFF_FFFF);
      checkOutput("ones tdi", tdiOnesSdr - s1, 0);
      checkOutput("ones sdr cycles", sdrCyc - s0, SRW * 4);
      checkOutput("ones tck rises", sdrRises - s3, SRW);
      finishRspA();
      tdoMode = 1'b0;

      $display("[TB] backpressure");
      applyStimulus(IR_OCIMEM, 38'h20_0000_0001, lat, rdata);
      checkOutput("bp data", rdata, 38'h20_0000_0001);
      irExpA    = IR_TRACECTRL;
      cmdIrA    = IR_TRACECTRL;
      cmdDataA  = 38'h1F_FFFF_FFFE;
      cmdValidA = 1'b1;
      holdBad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rspDataA !== rdata || rspValidA !== 1'b1 || cmdReadyA !== 1'b0 || vjUirA !== 1'b0)
            holdBad++;
      end
      checkOutput("bp hold stable", holdBad, 0);
      finishRspA();
      checkOutput("bp ready after rsp", cmdReadyA, 1);
      checkOutput("bp not yet accepted", vjUirA, 0);
      @(posedge clk);
      #1 cmdValidA = 1'b0;
      @(negedge clk);
      checkOutput("bp accepted", vjUirA, 1);
      checkOutput("bp busy", cmdReadyA, 0);
      waitRspA(lat, rdata);
      checkOutput("bp2 latency", lat + 0, LAT_A);
      checkOutput("bp2 data", rdata, 38'h1F_FFFF_FFFE);
      finishRspA();

      $display("[TB] reset mid-scan");
      @(negedge clk);
      irExpA    = IR_BREAK;
      cmdIrA    = IR_BREAK;
      cmdDataA  = 38'h3C_3C3C_3C3C;
      cmdValidA = 1'b1;
      @(posedge clk);
      #1 cmdValidA = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      checkOutput("mid in sdr", vjSdrA, 1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("mid strobes", {vjUirA, vjCdrA, vjSdrA, vjUdrA, vjRtiA, vjTckA, vjTdiA}, 0);
      checkOutput("mid ready", cmdReadyA, 1);
      rspSeen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rspValidA) rspSeen++;
      end
      checkOutput("mid no rsp", rspSeen, 0);
      applyStimulus(IR_TRACECTRL, 38'h15_1234_5678, lat, rdata);
      checkOutput("post reset latency", lat, LAT_A);
      checkOutput("post reset data", rdata, 38'h15_1234_5678);
      finishRspA();

`ifdef NIOS2_SCAN_MASTER_RTI_HOLD_EN
      $display("[TB] rti hold");
      rtiHoldA = 8'd3;
      s2 = rtiCyc;
      applyStimulus(IR_OCIMEM, 38'h0F_0F0F_0F0F, lat, rdata);
      rtiHoldA = 8'd0;
      checkOutput("hold latency", lat, LAT_A + 3 * 4);
      checkOutput("hold rti cycles", rtiCyc - s2, 16);
      checkOutput("hold data", rdata, 38'h0F_0F0F_0F0F);
      finishRspA();
`endif

      $display("[TB] back-to-back TCK_DIV=1");
      nAcc = 0; nRsp = 0; prevUirB = 1'b0; prevRspB = 1'b0;
      @(negedge clk);
      cmdDataB  = 38'h0A_BCDE_F012;
      cmdValidB = 1'b1;
      rspReadyB = 1'b1;
      for (int i = 0; i < 1000 && nRsp < 2; i++) begin
         @(negedge clk);
         if (vjUirB && !prevUirB && nAcc < 2) begin
            accB[nAcc] = cyc;
            nAcc++;
            if (nAcc == 2) cmdValidB = 1'b0;
         end
         if (rspValidB && !prevRspB && nRsp < 2) begin
            rspB[nRsp]  = cyc;
            dataB[nRsp] = rspDataB;
            nRsp++;
            cmdDataB = 38'h35_4321_0FED;
         end
         prevUirB = vjUirB;
         prevRspB = rspValidB;
      end
      cmdValidB = 1'b0;
      rspReadyB = 1'b0;
      checkOutput("b2b rsp count", nRsp, 2);
      checkOutput("b2b latency 1", rspB[0] - accB[0], LAT_B);
      checkOutput("b2b latency 2", rspB[1] - accB[1], LAT_B);
      checkOutput("b2b second accept", accB[1] - rspB[0], 2);
      checkOutput("b2b data 1", dataB[0], 38'h0A_BCDE_F012);
      checkOutput("b2b data 2", dataB[1], 38'h35_4321_0FED);

      repeat (4) @(negedge clk);
      checkOutput("tdi outside sdr", tdiOutside, 0);
      checkOutput("ir_in consistency", irBad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nios2_debug_scan_master.md
Name: nios2_debug_scan_master

Overview:
- Initiator side of the Nios II virtual-JTAG debug scan interface: drives tck/tdi/ir_in and the virtual state strobes (uir/cdr/sdr/udr/rti) into the CPU debug slave, and captures tdo.
- Runs one complete scan per command: load IR, capture DR, shift SR_WIDTH bits, update, run-test-idle.
- Lets simulation benches and on-chip debug agents reach the debug slave without a physical JTAG TAP.

Parameters:
- SR_WIDTH, 38, scan-chain length in bits (matches the debug slave shift register).
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per tck half-period; legal range ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  master idle and able to accept a request.
- cmd_ir  in  IR_WIDTH  IR value for this scan (00 ocimem, 01 tracemem, 10 break, 11 tracectrl).
- cmd_data  in  SR_WIDTH  DR value, shifted out LSB first.
- rsp_valid  out  1  captured data available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  SR_WIDTH  bits captured from tdo.
- vj_tck  out  1  virtual tck.
- vj_tdi  out  1  serial data to the slave.
- vj_tdo  in  1  serial data from the slave.
- vj_ir_in  out  IR_WIDTH  IR value presented to the slave.
- vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti  out  1 each  virtual state strobes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1. FSM goes to IDLE and the tck divider clears.
- Handshakes:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready. cmd_ir and cmd_data are registered at that edge.
  - cmd_ready is low from accept until the response handshake completes (rsp_valid && rsp_ready).
- tck generation:
  - A half-period counter counts 0..TCK_DIV-1. vj_tck toggles on wrap, and only outside IDLE and RSP.
  - Each scan state lasts exactly one tck period, 2*TCK_DIV clk cycles, starting with tck low.
- FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RSP -> IDLE.
  - In each state the matching strobe is held high for the entire state. SDR lasts SR_WIDTH tck periods.
  - vj_ir_in = latched cmd_ir from UIR through RTI; 0 in IDLE.
  - vj_tdi updates on tck falling edges (first bit valid at SDR entry) and is 0 outside SDR.
  - vj_tdo is sampled on every tck rising edge in SDR. The shift register shifts right with tdo entering the MSB, so after SR_WIDTH samples rsp_data[i] = i-th sampled bit.
  - RSP: rsp_valid=1 and rsp_data is held stable until rsp_ready. rsp_ready is ignored while rsp_valid=0.
- Latency: rsp_valid rises (SR_WIDTH+4)*2*TCK_DIV clk cycles after the accepting edge. Defaults give 168.
- Boundaries:
  - Reset mid-scan: immediate return to IDLE, all strobes and tck low next cycle, no response produced.
  - rsp_ready asserted in the same cycle rsp_valid rises completes the handshake. cmd_ready rises the following cycle.
  - cmd_valid held while busy is not accepted and not queued.
  - TCK_DIV=1 gives tck=clk/2.

Optional Feature:
- Macro: NIOS2_SCAN_MASTER_RTI_HOLD_EN.
- Defined:
  - Adds input rti_hold [7:0], sampled at accept.
  - RTI lasts 1+rti_hold tck periods, and latency grows by rti_hold*2*TCK_DIV.
  - Gives the slave's sysclk-domain take_action logic extra time after UDR.
- Undefined: the port is absent and RTI is fixed at one tck period.

Decomposition:
- Package nios2_debug_scan_pkg:
  - FSM state enum.
  - IR code constants (IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL).
  - Default SR_WIDTH/IR_WIDTH constants.
- One sub-module, nios2_scan_tck_gen: half-period counter plus tck register. Outputs vj_tck and single-cycle rise/fall pulses; has an enable input.

Test Plan:
- Loopback (vj_tdo tied to vj_tdi), cmd_ir=2'b10, cmd_data=38'h2A_5A5A_A5A5 -> rsp_data=38'h2A_5A5A_A5A5; rsp_valid at cycle 168; vj_ir_in=2'b10 throughout UIR..RTI.
- vj_tdo constant 1, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF; vj_tdi=0 for all 38 falling edges; vj_sdr high exactly 38*4 cycles.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_data stable, cmd_ready=0, and a pending cmd_valid is not accepted until the cycle after rsp_ready=1.
- Reset asserted at SDR bit 10 -> next cycle all strobes/tck/tdi=0, cmd_ready=1, no rsp_valid; a following scan completes normally.
- Back-to-back commands with rsp_ready=1, TCK_DIV=1 -> second accept one cycle after first response; each latency = 84 cycles.
- With NIOS2_SCAN_MASTER_RTI_HOLD_EN, rti_hold=3 -> vj_rti high 16 cycles, latency 168+12=180.
